// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write arbiter.
package fifo_arb_pkg;

  localparam int unsigned DEF_NUM_REQ    = 4;
  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_MAX_BURST  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Round-robin winner search: first set request strictly after last_id_i, wrapping.
module rr_pick #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] last_id_i,
  output logic [$clog2(N)-1:0] id_o,
  output logic                 any_o
);

  localparam int unsigned IdW = $clog2(N);

  // Scan from the farthest candidate back to the nearest so the nearest match is written last.
  always_comb begin
    id_o  = '0;
    any_o = |req_i;
    for (int unsigned i = N; i >= 1; i--) begin
      if (req_i[(32'(last_id_i) + i) % N]) begin
        id_o = IdW'((32'(last_id_i) + i) % N);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Burst-granting arbiter that merges NUM_REQ write streams into one shared FIFO.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned MAX_BURST  = DEF_MAX_BURST
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic                          fifo_full_i,
  output logic                          fifo_wr_en_o,
  output logic [DATA_WIDTH-1:0]         fifo_data_o,
  output logic                          grant_valid_o,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id_o
);

  localparam int unsigned IdW  = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(MAX_BURST) + 1;
  localparam logic [CntW-1:0] LastBeat = CntW'(MAX_BURST - 1);

  arb_state_e      state_q, state_d;
  logic [IdW-1:0]  grant_id_q, grant_id_d;
  logic [IdW-1:0]  last_id_q, last_id_d;
  logic [CntW-1:0] beat_cnt_q, beat_cnt_d;
  logic [IdW-1:0]  pick_id;
  logic            pick_any;
  logic            xfer;
  logic [DATA_WIDTH-1:0] req_words [NUM_REQ];

  rr_pick #(
    .N(NUM_REQ)
  ) u_rr_pick (
    .req_i     (req_valid_i),
    .last_id_i (last_id_q),
    .id_o      (pick_id),
    .any_o     (pick_any)
  );

  always_comb begin
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      req_words[k] = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      last_id_q  <= IdW'(NUM_REQ - 1);
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      last_id_q  <= last_id_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_id_d    = last_id_q;
    beat_cnt_d   = beat_cnt_q;
    req_ready_o  = '0;
    xfer         = 1'b0;
    fifo_wr_en_o = 1'b0;
    fifo_data_o  = '0;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_id_d = pick_id;
          beat_cnt_d = '0;
          state_d    = BURST;
        end
      end
      BURST: begin
        // Ready is also masked by reset so a burst cut by reset never writes.
        req_ready_o[grant_id_q] = !fifo_full_i && !rst_i;
        xfer = req_valid_i[grant_id_q] && req_ready_o[grant_id_q];
        if (xfer) begin
          fifo_wr_en_o = 1'b1;
          fifo_data_o  = req_words[grant_id_q];
          beat_cnt_d   = beat_cnt_q + 1'b1;
          if (req_last_i[grant_id_q] || (beat_cnt_q == LastBeat)) begin
            state_d    = IDLE;
            last_id_d  = grant_id_q;
            grant_id_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant_valid_o = (state_q == BURST);
  assign grant_id_o    = grant_valid_o ? grant_id_q : '0;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed-vector and random-scoreboard bench for fifo_wr_arb (4 requesters, 16-bit, burst 4).
module tb_fifo_wr_arb;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned MB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0] req_last;
  logic [NR-1:0] req_ready;
  logic          fifo_full;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_data;
  logic          grant_valid;
  logic [1:0]    grant_id;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fifo_wr_arb #(
    .NUM_REQ(NR),
    .DATA_WIDTH(DW),
    .MAX_BURST(MB)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_valid_i   (req_valid),
    .req_data_i    (req_data),
    .req_last_i    (req_last),
    .req_ready_o   (req_ready),
    .fifo_full_i   (fifo_full),
    .fifo_wr_en_o  (fifo_wr_en),
    .fifo_data_o   (fifo_data),
    .grant_valid_o (grant_valid),
    .grant_id_o    (grant_id)
  );

  typedef struct {
    logic       rst;
    logic [3:0] valid;
    logic [3:0] last;
    logic       full;
    logic [3:0] e_ready;
    logic       e_wr;
    logic [15:0] e_data;
    logic       e_gv;
    logic [1:0] e_gid;
  } vec_t;

  vec_t vecs[$];

  localparam logic [63:0] FIXED_DATA = 64'h4444_3333_2222_1111;

  task automatic add_v(input logic r, input logic [3:0] v, input logic [3:0] l, input logic f,
                       input logic [3:0] er, input logic ew, input logic [15:0] ed,
                       input logic egv, input logic [1:0] egid);
    vec_t t;
    t.rst = r; t.valid = v; t.last = l; t.full = f;
    t.e_ready = er; t.e_wr = ew; t.e_data = ed; t.e_gv = egv; t.e_gid = egid;
    vecs.push_back(t);
  endtask

  task automatic check(input string nm, input logic [3:0] er, input logic ew,
                       input logic [15:0] ed, input logic egv, input logic [1:0] egid);
    n_tests++;
    if (req_ready !== er || fifo_wr_en !== ew || fifo_data !== ed ||
        grant_valid !== egv || grant_id !== egid) begin
      n_fail++;
      $display("FAIL %s: got ready=%b wr=%b data=%h gv=%b gid=%0d, want ready=%b wr=%b data=%h gv=%b gid=%0d",
               nm, req_ready, fifo_wr_en, fifo_data, grant_valid, grant_id,
               er, ew, ed, egv, egid);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] v, input logic [3:0] l, input logic f);
    @(posedge clk);
    #1;
    rst = r; req_valid = v; req_last = l; fifo_full = f;
  endtask

  logic [11:0] seq [NR];
  logic [11:0] exp_seq [NR];
  int unsigned beats_in_grant;
  int unsigned n_writes;

  initial begin
    rst = 1'b1; req_valid = '0; req_last = '0; fifo_full = 1'b0; req_data = FIXED_DATA;
    repeat (2) @(posedge clk);

    // Reset state
    drive(1'b0, 4'b0000, 4'b0000, 1'b0);
    @(negedge clk);
    check("reset_state", 4'b0000, 1'b0, 16'h0000, 1'b0, 2'd0);

    // Round-robin single-beat grants 0,1,2,3,0 separated by IDLE
    add_v(0, 4'b1111, 4'b1111, 0, 4'b0000, 0, 16'h0000, 0, 0);
    add_v(0, 4'b1111, 4'b1111, 0, 4'b0001, 1, 16'h1111, 1, 0);
    add_v(0, 4'b1111, 4'b1111, 0, 4'b0000, 0, 16'h0000, 0, 0);
    add_v(0, 4'b1111, 4'b1111, 0, 4'b0010, 1, 16'h2222, 1, 1);
    add_v(0, 4'b1111, 4'b1111, 0, 4'b0000, 0, 16'h0000, 0, 0);
    add_v(0, 4'b1111, 4'b1111, 0, 4'b0100, 1, 16'h3333, 1, 2);
    add_v(0, 4'b1111, 4'b1111, 0, 4'b0000, 0, 16'h0000, 0, 0);
    add_v(0, 4'b1111, 4'b1111, 0, 4'b1000, 1, 16'h4444, 1, 3);
    add_v(0, 4'b1111, 4'b1111, 0, 4'b0000, 0, 16'h0000, 0, 0);
    add_v(0, 4'b1111, 4'b1111, 0, 4'b0001, 1, 16'h1111, 1, 0);
    add_v(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 16'h0000, 0, 0);
    // FIFO full stall for 3 cycles in the middle of requester 1's burst
    add_v(0, 4'b0010, 4'b0000, 0, 4'b0000, 0, 16'h0000, 0, 0);
    add_v(0, 4'b0010, 4'b0000, 0, 4'b0010, 1, 16'h2222, 1, 1);
    add_v(0, 4'b0010, 4'b0000, 1, 4'b0000, 0, 16'h0000, 1, 1);
    add_v(0, 4'b0010, 4'b0000, 1, 4'b0000, 0, 16'h0000, 1, 1);
    add_v(0, 4'b0010, 4'b0000, 1, 4'b0000, 0, 16'h0000, 1, 1);
    add_v(0, 4'b0010, 4'b0000, 0, 4'b0010, 1, 16'h2222, 1, 1);
    // Requester 1 drops valid for 2 cycles while 3 waits
    add_v(0, 4'b1000, 4'b0000, 0, 4'b0010, 0, 16'h0000, 1, 1);
    add_v(0, 4'b1000, 4'b0000, 0, 4'b0010, 0, 16'h0000, 1, 1);
    add_v(0, 4'b1010, 4'b0010, 0, 4'b0010, 1, 16'h2222, 1, 1);
    add_v(0, 4'b1010, 4'b0000, 0, 4'b0000, 0, 16'h0000, 0, 0);
    add_v(0, 4'b1000, 4'b1000, 0, 4'b1000, 1, 16'h4444, 1, 3);
    add_v(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 16'h0000, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].valid, vecs[i].last, vecs[i].full);
      @(negedge clk);
      check($sformatf("vec%0d", i), vecs[i].e_ready, vecs[i].e_wr, vecs[i].e_data,
            vecs[i].e_gv, vecs[i].e_gid);
    end

    // Requester 2 alone, 6-beat packet split by MAX_BURST into 4 + 2
    begin
      logic exp_gv [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      int beat = 1;
      for (int c = 0; c < 9; c++) begin
        drive(1'b0, (c < 8) ? 4'b0100 : 4'b0000, (beat == 6) ? 4'b0100 : 4'b0000, 1'b0);
        req_data[2*DW +: DW] = 16'h0200 + 16'(beat);
        @(negedge clk);
        check($sformatf("split%0d", c), exp_gv[c] ? 4'b0100 : 4'b0000, exp_gv[c],
              exp_gv[c] ? 16'h0200 + 16'(beat) : 16'h0000, exp_gv[c], exp_gv[c] ? 2'd2 : 2'd0);
        if (exp_gv[c]) beat++;
      end
      req_data = FIXED_DATA;
    end

    // Reset pulse after beat 2 of requester 3's burst; requester 0 wins afterwards
    drive(0, 4'b1011, 4'b0000, 0); @(negedge clk);
    check("mrst_idle", 4'b0000, 0, 16'h0000, 0, 0);
    drive(0, 4'b1011, 4'b0000, 0); @(negedge clk);
    check("mrst_beat1", 4'b1000, 1, 16'h4444, 1, 3);
    drive(0, 4'b1011, 4'b0000, 0); @(negedge clk);
    check("mrst_beat2", 4'b1000, 1, 16'h4444, 1, 3);
    drive(1, 4'b1011, 4'b0000, 0); @(negedge clk);
    n_tests++;
    if (req_ready !== 4'b0000 || fifo_wr_en !== 1'b0 || fifo_data !== 16'h0000) begin
      n_fail++;
      $display("FAIL mrst_during: got ready=%b wr=%b data=%h, want ready=0000 wr=0 data=0000",
               req_ready, fifo_wr_en, fifo_data);
    end
    drive(0, 4'b1011, 4'b0000, 0); @(negedge clk);
    check("mrst_after", 4'b0000, 0, 16'h0000, 0, 0);
    drive(0, 4'b1011, 4'b0001, 0); @(negedge clk);
    check("mrst_regrant0", 4'b0001, 1, 16'h1111, 1, 0);
    drive(0, 4'b0000, 4'b0000, 0); @(negedge clk);
    check("mrst_end", 4'b0000, 0, 16'h0000, 0, 0);

    // Random traffic scoreboard
    for (int k = 0; k < NR; k++) begin seq[k] = '0; exp_seq[k] = '0; end
    beats_in_grant = 0;
    n_writes = 0;
    for (int c = 0; c < 800; c++) begin
      @(posedge clk);
      #1;
      rst = 1'b0;
      req_valid = 4'($urandom_range(0, 15));
      fifo_full = ($urandom_range(0, 2) == 0);
      for (int k = 0; k < NR; k++) begin
        req_last[k] = ($urandom_range(0, 3) == 0);
        req_data[k*DW +: DW] = {4'(k), seq[k]};
      end
      @(negedge clk);
      n_tests++;
      if ((fifo_wr_en !== |(req_valid & req_ready)) ||
          (fifo_full && req_ready !== 4'b0000) ||
          ((req_ready & ~(4'b0001 << grant_id)) !== 4'b0000) ||
          (!grant_valid && (req_ready !== 4'b0000 || grant_id !== 2'd0)) ||
          (!fifo_wr_en && fifo_data !== 16'h0000)) begin
        n_fail++;
        $display("FAIL rand_ctrl c%0d: got ready=%b wr=%b data=%h gv=%b gid=%0d, inputs valid=%b full=%b",
                 c, req_ready, fifo_wr_en, fifo_data, grant_valid, grant_id, req_valid, fifo_full);
      end
      if (!grant_valid) beats_in_grant = 0;
      if (fifo_wr_en === 1'b1) begin
        n_tests++;
        n_writes++;
        beats_in_grant++;
        if (fifo_full || !grant_valid || fifo_data !== {2'b00, grant_id, exp_seq[grant_id]} ||
            beats_in_grant > MB) begin
          n_fail++;
          $display("FAIL rand_write c%0d: got data=%h full=%b gv=%b beats=%0d, want data=%h full=0 gv=1 beats<=%0d",
                   c, fifo_data, fifo_full, grant_valid, beats_in_grant,
                   {2'b00, grant_id, exp_seq[grant_id]}, MB);
        end
        exp_seq[grant_id] = exp_seq[grant_id] + 12'd1;
      end
      for (int k = 0; k < NR; k++) begin
        if (req_valid[k] && req_ready[k]) seq[k] = seq[k] + 12'd1;
      end
    end
    n_tests++;
    if (n_writes == 0) begin
      n_fail++;
      $display("FAIL rand_progress: got %0d writes, want at least 1", n_writes);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
